fft_stage_out_serializer: RTL
=============================

// Module: fft_stage_out_serializer
// PURPOSE
//  Receiving end of the FFT stage output interface: captures one ARRAY-lane block (IN_W-bit re/im per lane) on a
//  single-cycle valid pulse, rounds and saturates each lane to OUT_W bits, and streams the lanes one per cycle.
//  The output uses a valid/ready handshake. Ping-pong double buffer; the upstream stage has no backpressure,
//  so a block that arrives while both banks are full is dropped and flagged.
// PARAMETERS
//  ARRAY  16  lanes per block (power of 2, >=2)
//  IN_W   25  input lane width (signed)
//  OUT_W  14  output sample width (signed), OUT_W < IN_W-SHIFT+1
//  SHIFT  9   right-shift applied before saturation (>=1)
// PORTS
//  clk        in   1               clock, rising edge
//  rstn       in   1               async active-low reset
//  valid_in   in   1               1-cycle pulse: block on din_re/din_im valid
//  din_re     in   IN_W x ARRAY    signed real lanes
//  din_im     in   IN_W x ARRAY    signed imag lanes
//  dout_valid out  1               output sample valid
//  dout_ready in   1               downstream accepts sample
//  dout_re    out  OUT_W           signed real sample
//  dout_im    out  OUT_W           signed imag sample
//  dout_idx   out  $clog2(ARRAY)   lane index of current sample
//  dout_last  out  1               high with lane ARRAY-1
//  blk_drop   out  1               sticky: a block was dropped
//  drop_clr   in   1               synchronous clear of blk_drop
// BEHAVIOUR
//  - Reset is asynchronous on rstn. Reset clears all outputs, both bank-full flags, wr_bank and rd_bank to 0,
//    and the lane counter to 0. Buffer contents are don't-care after reset.
//  - Arithmetic is applied per lane at capture: y = (x + 2^(SHIFT-1)) >>> SHIFT (round half up, arithmetic shift),
//    computed in IN_W+1 bits. The result is then saturated to [-2^(OUT_W-1), 2^(OUT_W-1)-1]. Banks store OUT_W-bit values.
//  - Capture: on valid_in, if bank[wr_bank] is free, write all lanes into it, set it full, and toggle wr_bank.
//    Otherwise drop the block, set blk_drop, and leave the banks unchanged.
//  - A bank counts as free if it is not full, or if it is the read bank and its last sample handshakes in the same cycle.
//    In that simultaneous case the new block is accepted into that bank.
//  - Read FSM:
//    IDLE -> STREAM when bank[rd_bank] is full.
//    STREAM holds dout_valid=1 and presents bank[rd_bank][cnt].
//    A handshake is dout_valid & dout_ready. Each handshake increments cnt.
//    On the handshake with cnt==ARRAY-1: clear the bank's full flag, toggle rd_bank, set cnt=0, then go to STREAM if
//    the other bank is full (no bubble), else to IDLE.
//  - Latency: with valid_in at edge k and the FSM idle, dout_valid=1 with lane 0 after edge k, i.e. in the next cycle.
//    The outputs are registered.
//  - While dout_valid=1 and dout_ready=0, dout_re, dout_im, dout_idx and dout_last stay stable.
//  - dout_last = dout_valid & (cnt==ARRAY-1). dout_idx = cnt.
//  - blk_drop: a set in the same cycle as drop_clr wins, so blk_drop stays 1. Otherwise drop_clr clears it next cycle.
//  - If valid_in pulses on consecutive cycles, each pulse is evaluated independently.
//    With both banks empty: block 1 goes to bank 0, block 2 to bank 1, and block 3 is dropped unless freed that cycle.
//  - If rstn is asserted mid-stream, the in-flight block is discarded. No partial output follows release.
// TESTING
//  1. SHIFT=9, OUT_W=14. Lane i re=1280, im=-256 (all lanes), one pulse, ready=1 -> 16 beats, re=3, im=0,
//     idx 0..15, last on beat 16 only.
//  2. Saturation. re=16777215, im=-16777216 -> re=8191, im=-8192. Also re=-257 -> -1, and re=255 -> 0.
//  3. Backpressure. Toggle dout_ready 1010... -> 16 accepted beats in order. Outputs never change while valid&!ready.
//  4. Three pulses 1 cycle apart, ready=0 -> blocks 1 and 2 are stored, block 3 dropped, blk_drop=1.
//     Then ready=1 -> exactly 32 beats (block 1 then block 2, no gap between them).
//  5. Both banks full and the last handshake of the read bank coincides with valid_in -> block accepted, blk_drop stays 0.
//     Then 48 beats total, in order.
//  6. Assert rstn low at beat 7 -> dout_valid=0, blk_drop=0 immediately. After release, idle until the next valid_in.
//     Also: drop_clr coinciding with a drop -> blk_drop remains 1.

Source files
------------

// File: rtl/fft_stage_out_serializer.sv
// Captures an ARRAY-lane FFT block on a one-cycle pulse, rounds/saturates each lane and streams one lane per cycle.
// First sample is valid the cycle after capture; stalls hold the outputs; blocks arriving with both banks full are dropped.
module fft_stage_out_serializer #(
  parameter int ARRAY = 16,
  parameter int IN_W  = 25,
  parameter int OUT_W = 14,
  parameter int SHIFT = 9
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     valid_in,
  input  logic [ARRAY*IN_W-1:0]    din_re,
  input  logic [ARRAY*IN_W-1:0]    din_im,
  output logic                     dout_valid,
  input  logic                     dout_ready,
  output logic signed [OUT_W-1:0]  dout_re,
  output logic signed [OUT_W-1:0]  dout_im,
  output logic [$clog2(ARRAY)-1:0] dout_idx,
  output logic                     dout_last,
  output logic                     blk_drop,
  input  logic                     drop_clr
);
  localparam int CW = $clog2(ARRAY);
  localparam logic [CW-1:0] LAST_LANE = CW'(ARRAY - 1);
  localparam logic signed [IN_W:0] HALF    = (IN_W+1)'(1) << (SHIFT - 1);
  localparam logic signed [IN_W:0] SAT_MAX = (IN_W+1)'(2**(OUT_W-1) - 1);
  localparam logic signed [IN_W:0] SAT_MIN = ~SAT_MAX;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_STREAM = 1'b1;

  // Round half up then saturate; IN_W+1 bits keeps the rounding add from overflowing.
  function automatic logic signed [OUT_W-1:0] rnd_sat(input logic [IN_W-1:0] x);
    logic signed [IN_W:0] s;
    s = {x[IN_W-1], x};
    s = (s + HALF) >>> SHIFT;
    if (s > SAT_MAX)
      return SAT_MAX[OUT_W-1:0];
    else if (s < SAT_MIN)
      return SAT_MIN[OUT_W-1:0];
    else
      return s[OUT_W-1:0];
  endfunction

  logic signed [OUT_W-1:0] rnd_re [ARRAY];
  logic signed [OUT_W-1:0] rnd_im [ARRAY];
  logic signed [OUT_W-1:0] bank_re [2][ARRAY];
  logic signed [OUT_W-1:0] bank_im [2][ARRAY];

  logic [0:0]    state;
  logic [1:0]    full, full_nxt;
  logic          wr_bank, rd_bank, rd_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          hs, last_hs, wr_free, cap, drop, valid_nxt, byp;

  always_comb begin
    for (int i = 0; i < ARRAY; i++) begin
      rnd_re[i] = rnd_sat(din_re[i*IN_W +: IN_W]);
      rnd_im[i] = rnd_sat(din_im[i*IN_W +: IN_W]);
    end
  end

  assign dout_valid = (state == ST_STREAM);
  assign dout_idx   = cnt;
  assign hs         = dout_valid & dout_ready;
  assign last_hs    = hs & (cnt == LAST_LANE);
  // The read bank becomes writable in the very cycle its final sample leaves.
  assign wr_free    = ~full[wr_bank] | (last_hs & (wr_bank == rd_bank));
  assign cap        = valid_in & wr_free;
  assign drop       = valid_in & ~wr_free;
  assign rd_nxt     = rd_bank ^ last_hs;
  assign byp        = cap & (wr_bank == rd_nxt);

  always_comb begin
    full_nxt = full;
    if (last_hs) full_nxt[rd_bank] = 1'b0;
    if (cap)     full_nxt[wr_bank] = 1'b1;
  end

  always_comb begin
    cnt_nxt = cnt;
    if (last_hs)
      cnt_nxt = '0;
    else if (hs)
      cnt_nxt = cnt + CW'(1);
  end

  assign valid_nxt = full_nxt[rd_nxt];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= ST_IDLE;
      full      <= '0;
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      cnt       <= '0;
      dout_re   <= '0;
      dout_im   <= '0;
      dout_last <= 1'b0;
      blk_drop  <= 1'b0;
    end else begin
      state   <= valid_nxt ? ST_STREAM : ST_IDLE;
      full    <= full_nxt;
      rd_bank <= rd_nxt;
      cnt     <= cnt_nxt;
      if (cap) wr_bank <= ~wr_bank;
      // Freshly captured data bypasses the bank so lane 0 appears the next cycle.
      if (valid_nxt) begin
        dout_re <= byp ? rnd_re[cnt_nxt] : bank_re[rd_nxt][cnt_nxt];
        dout_im <= byp ? rnd_im[cnt_nxt] : bank_im[rd_nxt][cnt_nxt];
      end else begin
        dout_re <= '0;
        dout_im <= '0;
      end
      dout_last <= valid_nxt & (cnt_nxt == LAST_LANE);
      if (drop)
        blk_drop <= 1'b1;
      else if (drop_clr)
        blk_drop <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (cap) begin
      for (int i = 0; i < ARRAY; i++) begin
        bank_re[wr_bank][i] <= rnd_re[i];
        bank_im[wr_bank][i] <= rnd_im[i];
      end
    end
  end

endmodule
